// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider.
// Holds the controller state encoding and the default operand width used
// by the divider top level and its controller.
package div_pkg;

  // Default operand/result width of the divider.
  localparam int DIV_WIDTH_DEFAULT = 8;

  // Controller states: waiting for a request, iterating, presenting results.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_controller.sv
// Sequencing FSM and bit counter for the restoring divider.
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   start_i        division request, only honoured in IDLE
//   divisorZero_i  the divisor presented with start_i is zero
//   load_o         accept strobe for a normal division (load the datapath)
//   shift_o        one restoring iteration happens on this edge
//   finish_o       last iteration: capture the computed results
//   dbzFinish_o    accept of a zero divisor: capture the fixed dbz results
//   busy_o         an operation is in progress (RUN or DONE)
//   done_o         results are valid this cycle
module div_controller
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic divisorZero_i,
  output logic load_o,
  output logic shift_o,
  output logic finish_o,
  output logic dbzFinish_o,
  output logic busy_o,
  output logic done_o
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  // State and bit counter registers; reset returns to IDLE with a cleared count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state and strobe logic. The final iteration (count 1) happens on the
  // same edge that enters DONE, so results are captured from the datapath's
  // next values and the counter lands on 0 exactly as DONE is entered.
  // A zero divisor skips RUN entirely and enters DONE on the accept edge.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    load_o      = 1'b0;
    shift_o     = 1'b0;
    finish_o    = 1'b0;
    dbzFinish_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (divisorZero_i) begin
            state_d     = DONE;
            dbzFinish_o = 1'b1;
          end else begin
            state_d = RUN;
            count_d = CW'(WIDTH);
            load_o  = 1'b1;
          end
        end
      end
      RUN: begin
        shift_o = 1'b1;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d  = DONE;
          finish_o = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status is decoded straight from the state register.
  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

endmodule

// File: rtl/divider.sv
// Unsigned restoring shift-subtract divider, one quotient bit per clock, MSB first.
// Ports:
//   clk_in     clock, rising edge
//   rst_in     asynchronous active-high reset
//   start      request, accepted only when idle
//   dividend   numerator, sampled on the accept edge
//   divisor    denominator, sampled on the accept edge
//   quotient   registered result, updated on entry to DONE
//   remainder  registered result, updated on entry to DONE
//   busy       high from the accept edge until DONE is left
//   done       one-cycle pulse when results are valid
//   dbz        divide-by-zero flag, held alongside the results
module divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  logic load, shift, finish, dbzFinish;

  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH+1:0] trial;
  logic             trialNeg;
  logic [WIDTH:0]   remNext;
  logic [WIDTH-1:0] shiftNext;

  div_controller #(
    .WIDTH(WIDTH)
  ) u_ctrl (
    .clk_i        (clk_in),
    .rst_i        (rst_in),
    .start_i      (start),
    .divisorZero_i(divisor == '0),
    .load_o       (load),
    .shift_o      (shift),
    .finish_o     (finish),
    .dbzFinish_o  (dbzFinish),
    .busy_o       (busy),
    .done_o       (done)
  );

  // One restoring iteration. The partial remainder is always below the
  // divisor, so {rem, next dividend bit} fits in WIDTH+1 bits; one extra bit
  // on the trial difference holds the borrow that marks a negative result.
  always_comb begin
    trial     = {rem_q, shift_q[WIDTH-1]} - {2'b00, div_q};
    trialNeg  = trial[WIDTH+1];
    remNext   = trialNeg ? {rem_q[WIDTH-1:0], shift_q[WIDTH-1]} : trial[WIDTH:0];
    shiftNext = {shift_q[WIDTH-2:0], ~trialNeg};
  end

  // Datapath next-state: load on accept, iterate in RUN, and capture results
  // only on entry to DONE so the outputs hold between operations.
  always_comb begin
    rem_d       = rem_q;
    shift_d     = shift_q;
    div_d       = div_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    if (load) begin
      rem_d   = '0;
      shift_d = dividend;
      div_d   = divisor;
    end else if (shift) begin
      rem_d   = remNext;
      shift_d = shiftNext;
    end
    if (finish) begin
      quotient_d  = shiftNext;
      remainder_d = remNext[WIDTH-1:0];
      dbz_d       = 1'b0;
    end else if (dbzFinish) begin
      quotient_d  = '1;
      remainder_d = dividend;
      dbz_d       = 1'b1;
    end
  end

  // Datapath and result registers, all cleared by reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rem_q       <= '0;
      shift_q     <= '0;
      div_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      shift_q     <= shift_d;
      div_q       <= div_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the 8-bit divider.
module tb_divider;

  logic       clk_in;
  logic       rst_in;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       dbz;

  int total = 0;
  int bad   = 0;
  int lat;
  int pulses;

  divider #(
    .WIDTH(8)
  ) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy),
    .done     (done),
    .dbz      (dbz)
  );

  // 10 ns clock.
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Single comparison point: counts every check and reports each miss.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance until done is seen, counting cycles; bounded so a stuck DUT
  // shows up as a latency miss instead of a hang.
  task automatic waitDone();
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk_in);
      #1;
      lat++;
    end
  endtask

  // One complete operation with a start pulse. Operands are scrambled right
  // after the accept edge so any late sampling corrupts the result.
  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input int expLat, input logic [7:0] expQ,
                               input logic [7:0] expR, input logic expDbz);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk_in);
    #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = b + 8'd3;
    lat      = 1;
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    waitDone();
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_q"}, 32'(quotient), 32'(expQ));
    checkOutput({tag, "_r"}, 32'(remainder), 32'(expR));
    checkOutput({tag, "_dbz"}, 32'(dbz), 32'(expDbz));
    @(posedge clk_in);
    #1;
    checkOutput({tag, "_donePulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_in   = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;

    // Reset values.
    #12;
    checkOutput("rst_q", 32'(quotient), 32'd0);
    checkOutput("rst_r", 32'(remainder), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_dbz", 32'(dbz), 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    // 100/7 = 14 r 2, nine cycles.
    applyStimulus("d100_7", 8'd100, 8'd7, 9, 8'd14, 8'd2, 1'b0);

    // 255/1 with start held high, then 5/9 accepted on the first IDLE cycle.
    dividend = 8'd255;
    divisor  = 8'd1;
    start    = 1'b1;
    @(posedge clk_in);
    #1;
    lat      = 1;
    dividend = 8'd5;
    divisor  = 8'd9;
    waitDone();
    checkOutput("b2b1_lat", lat, 9);
    checkOutput("b2b1_q", 32'(quotient), 32'd255);
    checkOutput("b2b1_r", 32'(remainder), 32'd0);
    @(posedge clk_in);
    #1;
    checkOutput("b2b_idle", 32'(busy), 32'd0);
    @(posedge clk_in);
    #1;
    checkOutput("b2b2_accept", 32'(busy), 32'd1);
    start = 1'b0;
    lat   = 1;
    waitDone();
    checkOutput("b2b2_lat", lat, 9);
    checkOutput("b2b2_q", 32'(quotient), 32'd0);
    checkOutput("b2b2_r", 32'(remainder), 32'd5);
    checkOutput("b2b2_dbz", 32'(dbz), 32'd0);
    @(posedge clk_in);
    #1;

    // Divide by zero, then confirm the flag and results hold in IDLE.
    applyStimulus("d200_0", 8'd200, 8'd0, 1, 8'd255, 8'd200, 1'b1);
    @(posedge clk_in);
    #1;
    checkOutput("dbz_holdFlag", 32'(dbz), 32'd1);
    checkOutput("dbz_holdQ", 32'(quotient), 32'd255);
    applyStimulus("d200_10", 8'd200, 8'd10, 9, 8'd20, 8'd0, 1'b0);

    // 60/7 = 8 r 4; a start pulse with 99/3 in RUN must be ignored.
    dividend = 8'd60;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk_in);
    #1;
    start = 1'b0;
    lat   = 1;
    repeat (3) begin
      @(posedge clk_in);
      #1;
      lat++;
    end
    dividend = 8'd99;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk_in);
    #1;
    lat++;
    start = 1'b0;
    waitDone();
    checkOutput("ignore_lat", lat, 9);
    checkOutput("ignore_q", 32'(quotient), 32'd8);
    checkOutput("ignore_r", 32'(remainder), 32'd4);
    @(posedge clk_in);
    #1;

    // Asynchronous reset in RUN cycle 4 of 50/3: outputs clear at once,
    // no done pulse follows, and the next request works normally.
    dividend = 8'd50;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk_in);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk_in);
      #1;
    end
    #2;
    rst_in = 1'b1;
    #1;
    checkOutput("midrst_q", 32'(quotient), 32'd0);
    checkOutput("midrst_r", 32'(remainder), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_dbz", 32'(dbz), 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk_in);
      #1;
      if (done === 1'b1) pulses++;
    end
    checkOutput("midrst_noDone", pulses, 0);
    applyStimulus("d81_9", 8'd81, 8'd9, 9, 8'd9, 8'd0, 1'b0);

    // Random operand pairs against a reference division.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if (i % 50 == 0) b = 8'd0;
      if (b == 8'd0)
        applyStimulus("rand", a, b, 1, 8'hFF, a, 1'b1);
      else
        applyStimulus("rand", a, b, 9, a / b, a % b, 1'b0);
    end

    $display("[TB] directed and random sequences complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
